// File: rtl/axis_bram_adapter_pkg.sv
// Shared constants and row-slice helpers for the AXIS<->BRAM adapter.
package axis_bram_adapter_pkg;

  // Source encoding carried in the low bit of each {change, src} pair.
  localparam logic SRC_BRAM = 1'b0;
  localparam logic SRC_AXIS = 1'b1;

  // LSB of word k inside a packed row; word 0 occupies the MSBs.
  function automatic int word_lsb(input int k, input int n, input int w);
    return w * (n - 1 - k);
  endfunction

  // LSB of the {change, src} pair for word k; pair 0 occupies the MSBs.
  function automatic int pair_lsb(input int k, input int n);
    return 2 * (n - 1 - k);
  endfunction

endpackage

// File: rtl/axis_bram_adapter_v1_0_skid.sv
// Two-entry skid buffer with fully registered outputs. in_ready depends only
// on local state, so the upstream accept never sees out_ready combinationally.
module axis_bram_adapter_v1_0_skid #(
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  skid_valid_reg;
  logic                  in_fire;

  // Accept while the second (skid) entry is free.
  assign in_ready  = ~skid_valid_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

  // Output entry refills from the skid entry first to keep FIFO order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= in_fire;
        if (in_fire) begin
          out_data_reg <= in_data;
        end
      end
    end else if (in_fire) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_bram_adapter_v1_0_rowbuf.sv
// Row-buffer datapath: assembles stream words into a BRAM row on writes and
// serialises a captured BRAM row onto the master stream on reads.
// Optional registered output stage: define AXIS_BRAM_ROWBUF_OUTREG_EN.
module axis_bram_adapter_v1_0_rowbuf
  import axis_bram_adapter_pkg::*;
#(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_ROW   = 36,
  parameter int SEL_BITS        = 6,
  parameter int BRAM_RD_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [2*WORDS_PER_ROW-1:0]          from_axis_mux_cntl,
  input  logic [SEL_BITS-1:0]                 to_axis_mux_cntl,
  input  logic                                rw,
  input  logic                                stream_in_accep,
  input  logic                                stream_out_valid,
  input  logic                                stream_out_tlast,
  output logic                                stream_out_accep,
  input  logic [WORD_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                bram_en,
  input  logic                                bram_wen,
  input  logic [WORDS_PER_ROW*WORD_WIDTH-1:0] bram_dout,
  output logic [WORDS_PER_ROW*WORD_WIDTH-1:0] bram_din,
  output logic [WORD_WIDTH-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready
);

  localparam int N = WORDS_PER_ROW;
  localparam int W = WORD_WIDTH;
  localparam logic [SEL_BITS:0] NUM_WORDS = (SEL_BITS + 1)'(N);

  logic [W-1:0]               row_reg   [N];
  logic [W-1:0]               row_next  [N];
  logic [W-1:0]               bram_word [N];
  logic [1:0]                 pair      [N];
  logic [BRAM_RD_LATENCY-1:0] rd_pipe_reg;
  logic                       rd_req;
  logic                       rd_valid;
  logic                       axis_fire;
  logic [W-1:0]               word_sel;

  assign s_axis_tready = stream_in_accep;
  assign axis_fire     = s_axis_tvalid & stream_in_accep & rw;
  assign rd_req        = bram_en & ~bram_wen;
  assign rd_valid      = rd_pipe_reg[BRAM_RD_LATENCY-1];

  // Unpack control pairs and BRAM words; repack the row onto bram_din.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign pair[gi]      = from_axis_mux_cntl[pair_lsb(gi, N) +: 2];
    assign bram_word[gi] = bram_dout[word_lsb(gi, N, W) +: W];
    assign bram_din[word_lsb(gi, N, W) +: W] = row_reg[gi];
  end

  // Read-request delay line matching the BRAM read latency.
  if (BRAM_RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rstn) rd_pipe_reg <= '0;
      else       rd_pipe_reg <= rd_req;
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (!rstn) rd_pipe_reg <= '0;
      else       rd_pipe_reg <= {rd_pipe_reg[BRAM_RD_LATENCY-2:0], rd_req};
    end
  end

  // Per-word load selection; AXIS and BRAM loads on different words coexist.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      row_next[k] = row_reg[k];
      if (pair[k][1]) begin
        if (pair[k][0] == SRC_AXIS) begin
          if (axis_fire) row_next[k] = s_axis_tdata;
        end else if (rd_valid) begin
          row_next[k] = bram_word[k];
        end
      end
    end
  end

  // Row register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) row_reg[k] <= '0;
    end else begin
      row_reg <= row_next;
    end
  end

  // Word select for the master stream; out-of-range indices read as zero.
  always_comb begin
    word_sel = '0;
    if ({1'b0, to_axis_mux_cntl} < NUM_WORDS) word_sel = row_reg[to_axis_mux_cntl];
  end

`ifdef AXIS_BRAM_ROWBUF_OUTREG_EN
  logic [W:0] skid_out;

  axis_bram_adapter_v1_0_skid #(
    .DATA_WIDTH(W + 1)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  ({stream_out_tlast, word_sel}),
    .in_valid (stream_out_valid & ~rw),
    .in_ready (stream_out_accep),
    .out_data (skid_out),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

  assign m_axis_tlast = skid_out[W];
  assign m_axis_tdata = skid_out[W-1:0];
`else
  assign m_axis_tdata     = word_sel;
  assign m_axis_tvalid    = stream_out_valid & ~rw;
  assign m_axis_tlast     = stream_out_tlast;
  assign stream_out_accep = m_axis_tready;
`endif

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_rowbuf.sv
// Directed self-checking bench for axis_bram_adapter_v1_0_rowbuf (default
// parameters, BRAM read latency 1).
module tb_axis_bram_adapter_v1_0_rowbuf;

  localparam int N  = 36;
  localparam int W  = 32;
  localparam int RW = N * W;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2*N-1:0] mux;
  logic [5:0]    sel;
  logic          rw, stream_in_accep, stream_out_valid, stream_out_tlast;
  logic          stream_out_accep;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic          bram_en, bram_wen;
  logic [RW-1:0] bram_dout, bram_din, exp_din;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int n_checks = 0;
  int n_fail   = 0;

  axis_bram_adapter_v1_0_rowbuf dut (
    .clk               (clk),
    .rstn              (rstn),
    .from_axis_mux_cntl(mux),
    .to_axis_mux_cntl  (sel),
    .rw                (rw),
    .stream_in_accep   (stream_in_accep),
    .stream_out_valid  (stream_out_valid),
    .stream_out_tlast  (stream_out_tlast),
    .stream_out_accep  (stream_out_accep),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .bram_en           (bram_en),
    .bram_wen          (bram_wen),
    .bram_dout         (bram_dout),
    .bram_din          (bram_din),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s mismatch", tag);
    end
    if (obs === expv) $display("ok   %s = %0h", tag, obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input int k, input logic [1:0] v);
    mux[2*(N-1-k) +: 2] = v;
  endtask

  task automatic set_exp(input int k, input logic [W-1:0] v);
    exp_din[W*(N-1-k) +: W] = v;
  endtask

  initial begin
    logic [RW-1:0] pat_a, pat_b, zero_row;
    zero_row = '0;
    for (int k = 0; k < N; k++) begin
      pat_a[W*(N-1-k) +: W] = 32'hA000 + 32'(k);
      pat_b[W*(N-1-k) +: W] = 32'hB000 + 32'(k);
    end

    // Reset with an AXIS load pending on word 0: reset must win.
    rstn = 1'b0; mux = '0; sel = '0; rw = 1'b1; stream_in_accep = 1'b1;
    stream_out_valid = 1'b0; stream_out_tlast = 1'b0; s_axis_tdata = 32'hDEAD;
    s_axis_tvalid = 1'b1; bram_en = 1'b0; bram_wen = 1'b0; bram_dout = '0;
    m_axis_tready = 1'b1; exp_din = '0;
    set_pair(0, 2'b11);
    step(); step(); step();
    check("reset_bram_din", bram_din, zero_row);
    check("reset_tvalid", RW'(m_axis_tvalid), RW'(1'b0));
    check("reset_tlast", RW'(m_axis_tlast), RW'(1'b0));

    // Write phase, no accept: word 0 must hold.
    rstn = 1'b1; stream_in_accep = 1'b0; s_axis_tdata = 32'h1000;
    #1;
    check("tready_follows_accep0", RW'(s_axis_tready), RW'(1'b0));
    step();
    check("no_accep_no_load", bram_din, exp_din);

    // Write the row one word per cycle, with a 5-cycle stall at word 10.
    stream_in_accep = 1'b1;
    stream_out_valid = 1'b1;
    #1;
    check("tready_follows_accep1", RW'(s_axis_tready), RW'(1'b1));
    check("write_mode_tvalid_low", RW'(m_axis_tvalid), RW'(1'b0));
    stream_out_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      mux = '0;
      set_pair(k, 2'b11);
      s_axis_tdata = 32'h1000 + 32'(k);
      if (k == 10) begin
        s_axis_tvalid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          check($sformatf("stall_hold_%0d", s), bram_din, exp_din);
        end
        s_axis_tvalid = 1'b1;
      end
      step();
      set_exp(k, 32'h1000 + 32'(k));
      check($sformatf("write_word_%0d", k), bram_din, exp_din);
    end

    // Controller writes the row: complete row already present.
    mux = '0; s_axis_tvalid = 1'b0; bram_en = 1'b1; bram_wen = 1'b1;
    #1;
    check("row_complete_at_wen", bram_din, exp_din);
    check("word0_in_msbs", RW'(bram_din[RW-1 -: W]), RW'(32'h1000));
    step();
    bram_en = 1'b0; bram_wen = 1'b0;

    // Premature BRAM change bits (and the write pulse) must not load.
    rw = 1'b0; bram_dout = pat_a;
    for (int k = 0; k < N; k++) set_pair(k, 2'b10);
    step();
    check("premature_bram_hold_0", bram_din, exp_din);
    step();
    check("premature_bram_hold_1", bram_din, exp_din);

    // Read: bram_en for one cycle, row updates on the second edge.
    bram_en = 1'b1;
    step();
    bram_en = 1'b0;
    check("read_not_yet", bram_din, exp_din);
    step();
    exp_din = pat_a;
    check("read_row_loaded", bram_din, exp_din);
    mux = '0;

`ifndef AXIS_BRAM_ROWBUF_OUTREG_EN
    // Sweep the select; combinational output stage.
    stream_out_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      sel = 6'(k);
      stream_out_tlast = (k == N - 1);
      m_axis_tready = k[0];
      #1;
      check($sformatf("sweep_data_%0d", k), RW'(m_axis_tdata), RW'(32'hA000 + 32'(k)));
      check($sformatf("sweep_valid_%0d", k), RW'(m_axis_tvalid), RW'(1'b1));
      check($sformatf("sweep_last_%0d", k), RW'(m_axis_tlast), RW'(k == N - 1));
      check($sformatf("sweep_accep_%0d", k), RW'(stream_out_accep), RW'(k[0]));
    end
    sel = 6'd40;
    #1;
    check("sel_out_of_range", RW'(m_axis_tdata), RW'(0));
    rw = 1'b1;
    #1;
    check("rw1_tvalid_low", RW'(m_axis_tvalid), RW'(1'b0));
    rw = 1'b0; stream_out_valid = 1'b0; stream_out_tlast = 1'b0;
    step();
`else
    // Skid output stage: 36 beats with tready pattern 1,0,0,1.
    begin
      int in_idx, out_idx, occ, cyc;
      logic pat_rdy [4];
      logic in_fire, out_fire;
      pat_rdy[0] = 1'b1; pat_rdy[1] = 1'b0; pat_rdy[2] = 1'b0; pat_rdy[3] = 1'b1;
      in_idx = 0; out_idx = 0; occ = 0; cyc = 0;
      while (out_idx < N && cyc < 400) begin
        stream_out_valid = (in_idx < N);
        sel = 6'(in_idx);
        stream_out_tlast = (in_idx == N - 1);
        m_axis_tready = pat_rdy[cyc % 4];
        #1;
        check($sformatf("skid_accep_c%0d", cyc), RW'(stream_out_accep), RW'(occ < 2));
        in_fire  = stream_out_valid & stream_out_accep;
        out_fire = m_axis_tvalid & m_axis_tready;
        if (out_fire) begin
          check($sformatf("skid_data_%0d", out_idx), RW'(m_axis_tdata), RW'(32'hA000 + 32'(out_idx)));
          check($sformatf("skid_last_%0d", out_idx), RW'(m_axis_tlast), RW'(out_idx == N - 1));
          out_idx++;
        end
        step();
        if (in_fire) in_idx++;
        occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
        cyc++;
      end
      check("skid_all_beats", RW'(out_idx), RW'(N));
      stream_out_valid = 1'b0; stream_out_tlast = 1'b0; m_axis_tready = 1'b1;
      step();
      check("skid_drained_tvalid", RW'(m_axis_tvalid), RW'(1'b0));
    end
`endif

    // Partial row write to word 17 with a read in flight, then reset.
    rw = 1'b1; stream_in_accep = 1'b1; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 18; k++) begin
      mux = '0;
      set_pair(k, 2'b11);
      s_axis_tdata = 32'h2000 + 32'(k);
      if (k == 17) begin bram_en = 1'b1; bram_wen = 1'b0; end
      step();
      set_exp(k, 32'h2000 + 32'(k));
    end
    check("partial_row_17", bram_din, exp_din);
    s_axis_tvalid = 1'b0; bram_en = 1'b0; bram_dout = pat_b;
    for (int k = 0; k < N; k++) set_pair(k, 2'b10);
    rstn = 1'b0;
    step();
    check("midrow_reset_din", bram_din, zero_row);
    check("midrow_reset_tvalid", RW'(m_axis_tvalid), RW'(1'b0));
    rstn = 1'b1;
    step(); step();
    check("pending_read_dropped", bram_din, zero_row);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
